// File: rtl/uart_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : uart_prescaler
// Brief    : Board-clock divider producing a UART bit clock/tick, a heartbeat
//            blink, an RX activity link indicator and an RX break detector.
// Revision : 1.0  initial release
// ============================================================================
module uart_prescaler #(
   parameter int CLKRATE    = 12_000_000,
   parameter int BAUD0      = 300,
   parameter int BAUD1      = 9600,
   parameter int BAUD2      = 19200,
   parameter int BAUD3      = 115200,
   parameter int BLINKRATE  = 1,
   parameter int LINK_MS    = 50,
   parameter int BREAK_BITS = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic [1:0] baud_sel,
   output logic       uart_clk,
   output logic       uart_tick,
   output logic       blink,
   output logic       link,
   output logic       rx_break
);

   localparam int HALF0 = CLKRATE / (2 * BAUD0);
   localparam int HALF1 = CLKRATE / (2 * BAUD1);
   localparam int HALF2 = CLKRATE / (2 * BAUD2);
   localparam int HALF3 = CLKRATE / (2 * BAUD3);
   localparam int HALF01   = (HALF0 > HALF1) ? HALF0 : HALF1;
   localparam int HALF23   = (HALF2 > HALF3) ? HALF2 : HALF3;
   localparam int HALF_MAX = (HALF01 > HALF23) ? HALF01 : HALF23;
   localparam int BCW      = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

   // Terminal counts are stored as HALF-1 so a power-of-two HALF still fits BCW bits.
   localparam logic [BCW-1:0] C_TOP0 = BCW'(HALF0 - 1);
   localparam logic [BCW-1:0] C_TOP1 = BCW'(HALF1 - 1);
   localparam logic [BCW-1:0] C_TOP2 = BCW'(HALF2 - 1);
   localparam logic [BCW-1:0] C_TOP3 = BCW'(HALF3 - 1);

   localparam int BLINK_HALF = CLKRATE / (2 * BLINKRATE);
   localparam int BLW        = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [BLW-1:0] C_BLINK_TOP = BLW'(BLINK_HALF - 1);

   localparam int LINK_CYC = CLKRATE / 1000 * LINK_MS;
   localparam int LW       = $clog2(LINK_CYC + 1);
   localparam logic [LW-1:0] C_LINK_LOAD = LW'(LINK_CYC);

   localparam int BRW = $clog2(BREAK_BITS + 1);
   localparam logic [BRW-1:0] C_BREAK_MAX = BRW'(BREAK_BITS);

   logic [BCW-1:0] r_baud_cnt;
   logic [1:0]     r_sel;
   logic [BCW-1:0] w_top;
   logic           w_wrap;
   logic           r_uclk_d;

   logic [BLW-1:0] r_blink_cnt;

   logic           r_rx_m;
   logic           r_rx_s;
   logic           r_rx_d;
   logic           w_rx_edge;

   logic [LW-1:0]  r_link_cnt;
   logic [LW-1:0]  w_link_next;

   logic [BRW-1:0] r_brk_cnt;
   logic [BRW-1:0] w_brk_next;

   always_comb begin
      w_top = C_TOP0;
      unique case (r_sel)
         2'd0:    w_top = C_TOP0;
         2'd1:    w_top = C_TOP1;
         2'd2:    w_top = C_TOP2;
         default: w_top = C_TOP3;
      endcase
   end

   assign w_wrap = (r_baud_cnt == w_top);

   // The select is only sampled at a half-period boundary, so no runt halves occur.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_baud_cnt <= '0;
         r_sel      <= 2'd0;
         uart_clk   <= 1'b0;
         r_uclk_d   <= 1'b0;
         uart_tick  <= 1'b0;
      end else begin
         if (w_wrap) begin
            r_baud_cnt <= '0;
            uart_clk   <= ~uart_clk;
            r_sel      <= baud_sel;
         end else begin
            r_baud_cnt <= r_baud_cnt + BCW'(1);
         end
         r_uclk_d  <= uart_clk;
         uart_tick <= uart_clk & ~r_uclk_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_blink_cnt <= '0;
         blink       <= 1'b0;
      end else if (r_blink_cnt == C_BLINK_TOP) begin
         r_blink_cnt <= '0;
         blink       <= ~blink;
      end else begin
         r_blink_cnt <= r_blink_cnt + BLW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_m <= 1'b1;
         r_rx_s <= 1'b1;
         r_rx_d <= 1'b1;
      end else begin
         r_rx_m <= rx;
         r_rx_s <= r_rx_m;
         r_rx_d <= r_rx_s;
      end
   end

   assign w_rx_edge = r_rx_s ^ r_rx_d;

   // link is registered from the next count so it rises on the reload cycle itself.
   always_comb begin
      w_link_next = r_link_cnt;
      if (w_rx_edge) begin
         w_link_next = C_LINK_LOAD;
      end else if (r_link_cnt != '0) begin
         w_link_next = r_link_cnt - LW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_link_cnt <= '0;
         link       <= 1'b0;
      end else begin
         r_link_cnt <= w_link_next;
         link       <= (w_link_next != '0);
      end
   end

   always_comb begin
      w_brk_next = r_brk_cnt;
      if (r_rx_s) begin
         w_brk_next = '0;
      end else if (uart_tick && (r_brk_cnt != C_BREAK_MAX)) begin
         w_brk_next = r_brk_cnt + BRW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_brk_cnt <= '0;
         rx_break  <= 1'b0;
      end else begin
         r_brk_cnt <= w_brk_next;
         rx_break  <= (w_brk_next == C_BREAK_MAX);
      end
   end

endmodule
`default_nettype wire
